reflex_round_ctrl: RTL

- Sequences one reflex-training game: places each target ball, arms the hit window, times the player's reaction, handles timeouts and counts rounds to game over.
- Sits between the mouse hit detector and the VGA ball renderer.
- Consumes the detector's level-type `hit` signal. Drives ball position and the score and timing registers shown on the display.

---
 rtl/reflex_pkg.sv | 20 ++
 rtl/reflex_ms_timer.sv | 35 +++
 rtl/reflex_round_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex-training round controller.
package reflex_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    ARMED = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BALL_SIZE = 40;

  localparam int MS_W = 14;

  localparam logic [19:0] LFSR_SEED = 20'hACE1;

endpackage

// File: rtl/reflex_ms_timer.sv
// Millisecond time base: CLK_PER_MS divider plus a saturating ms counter,
// both cleared together so every timed interval starts on a fresh ms boundary.
module reflex_ms_timer
  import reflex_pkg::*;
#(
  parameter int CLK_PER_MS = 25000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  output logic            tick,
  output logic [MS_W-1:0] ms_count
);

  localparam int DIV_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_MS - 1);

  logic [DIV_W-1:0] div_reg;
  logic [MS_W-1:0]  ms_reg;

  assign tick     = (div_reg == DIV_LAST);
  assign ms_count = ms_reg;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      div_reg <= '0;
      ms_reg  <= '0;
    end else begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
      if (tick && (ms_reg != '1))
        ms_reg <= ms_reg + 1'b1;
    end
  end

endmodule

// File: rtl/reflex_round_ctrl.sv
// Reflex-game sequencer: spawns balls, times hits, counts misses and rounds.
// Optional fastest-hit tracking is enabled with REFLEX_BEST_TIME_EN.
module reflex_round_ctrl
  import reflex_pkg::*;
#(
  parameter int CLK_PER_MS = 25000,
  parameter int NUM_ROUNDS = 20,
  parameter int TIMEOUT_MS = 1500,
  parameter int GAP_MS     = 500,
  parameter int X_LIMIT    = SCREEN_W - BALL_SIZE,
  parameter int Y_LIMIT    = SCREEN_H - BALL_SIZE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            hit,
  output logic [9:0]      BALL_X,
  output logic [9:0]      BALL_Y,
  output logic            ball_visible,
  output logic [7:0]      score,
  output logic [7:0]      misses,
  output logic [7:0]      round_num,
  output logic [MS_W-1:0] react_ms,
  output logic            game_over,
  output logic [MS_W-1:0] best_ms
);

  localparam logic [9:0]      X_LIM        = 10'(X_LIMIT);
  localparam logic [9:0]      Y_LIM        = 10'(Y_LIMIT);
  localparam logic [7:0]      LAST_ROUND   = 8'(NUM_ROUNDS);
  localparam logic [MS_W-1:0] TIMEOUT_LAST = MS_W'(TIMEOUT_MS - 1);
  localparam logic [MS_W-1:0] GAP_LAST     = MS_W'(GAP_MS - 1);

  state_t          state_reg, state_next;
  logic            start_q, hit_q, start_rise, hit_rise;
  logic [19:0]     lfsr_reg;
  logic [9:0]      x_raw, y_raw, x_map, y_map;
  logic [9:0]      x_reg, y_reg;
  logic [7:0]      score_reg, miss_reg, round_reg;
  logic [MS_W-1:0] react_reg;
  logic            tick, timer_clr, timeout, gap_end;
  logic [MS_W-1:0] ms_count;

  assign start_rise = start & ~start_q;
  assign hit_rise   = hit & ~hit_q;

  // The window closes on the tick that carries the count to TIMEOUT_MS,
  // so ARMED lasts exactly TIMEOUT_MS ms; GAP ends the same way.
  assign timeout = tick && (ms_count == TIMEOUT_LAST);
  assign gap_end = tick && (ms_count == GAP_LAST);

  assign x_raw = lfsr_reg[9:0];
  assign y_raw = {1'b0, lfsr_reg[18:10]};
  assign x_map = (x_raw >= X_LIM) ? x_raw - X_LIM : x_raw;
  assign y_map = (y_raw >= Y_LIM) ? y_raw - Y_LIM : y_raw;

  reflex_ms_timer #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .tick    (tick),
    .ms_count(ms_count)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start_rise) state_next = SPAWN;
      SPAWN:      state_next = ARMED;
      ARMED:      if (hit_rise || timeout) state_next = GAP;
      GAP:        if (gap_end) state_next = (round_reg == LAST_ROUND) ? DONE : SPAWN;
      default:    state_next = IDLE;
    endcase
    timer_clr = (state_next != state_reg);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_q   <= 1'b0;
      hit_q     <= 1'b0;
      lfsr_reg  <= LFSR_SEED;
      x_reg     <= '0;
      y_reg     <= '0;
      score_reg <= '0;
      miss_reg  <= '0;
      round_reg <= '0;
      react_reg <= '0;
    end else begin
      start_q  <= start;
      hit_q    <= hit;
      lfsr_reg <= {lfsr_reg[18:0], lfsr_reg[19] ^ lfsr_reg[16]};
      case (state_reg)
        IDLE, DONE: begin
          if (start_rise) begin
            score_reg <= '0;
            miss_reg  <= '0;
            react_reg <= '0;
            round_reg <= 8'd1;
          end
        end
        SPAWN: begin
          x_reg <= x_map;
          y_reg <= y_map;
        end
        ARMED: begin
          if (hit_rise) begin
            react_reg <= ms_count;
            score_reg <= score_reg + 1'b1;
          end else if (timeout) begin
            miss_reg <= miss_reg + 1'b1;
          end
        end
        GAP: begin
          if (gap_end && (round_reg != LAST_ROUND))
            round_reg <= round_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef REFLEX_BEST_TIME_EN
  logic [MS_W-1:0] best_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      best_reg <= '1;
    end else if (((state_reg == IDLE) || (state_reg == DONE)) && start_rise) begin
      best_reg <= '1;
    end else if ((state_reg == ARMED) && hit_rise && (ms_count < best_reg)) begin
      best_reg <= ms_count;
    end
  end

  assign best_ms = best_reg;
`else
  assign best_ms = '1;
`endif

  assign BALL_X       = x_reg;
  assign BALL_Y       = y_reg;
  assign ball_visible = (state_reg == ARMED);
  assign game_over    = (state_reg == DONE);
  assign score        = score_reg;
  assign misses       = miss_reg;
  assign round_num    = round_reg;
  assign react_ms     = react_reg;

endmodule
